// File: rtl/mem_req_arb_pkg.sv
// Shared types and constants for the memory request arbiter.
package mem_req_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT_DONE
    } arb_state_t;

    // A single request may straddle a 4 KB boundary and become two bursts.
    localparam int CREDIT_RESERVE = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set bit of req at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] pos;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = pos;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter feeding one 4 KB splitter, throttled by an outstanding-burst credit count.
// Optional per-requester grant counters and credit error flag under MEM_REQ_ARB_STATS_EN.
module mem_req_arbiter
    import mem_req_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int REQ_SIZE_WIDTH  = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
    input  logic [NUM_REQ*REQ_SIZE_WIDTH-1:0]    req_size,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [ADDR_WIDTH-1:0]                split_addr,
    output logic [REQ_SIZE_WIDTH-1:0]            split_size,
    output logic                                 split_valid,
    input  logic                                 split_complete,
    input  logic                                 split_burst_valid,
    input  logic                                 resp_done,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id,
    output logic                                 busy,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
`ifdef MEM_REQ_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]                grant_count,
    output logic                                 credit_err
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t                state, state_next;
    logic [IDX_W-1:0]          rr_ptr;
    logic [NUM_REQ-1:0]        pick_onehot;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;
    logic                      credit_ok;
    logic                      grant_fire;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [REQ_SIZE_WIDTH-1:0] sel_size;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign sel_addr  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_size  = req_size[pick_idx*REQ_SIZE_WIDTH +: REQ_SIZE_WIDTH];
    assign credit_ok = (int'(outstanding) + CREDIT_RESERVE) <= MAX_OUTSTANDING;

    assign split_valid = (state == ISSUE);
    assign busy        = (state != IDLE);

    // req_ready is gated by reset so no accept pulse can escape during reset.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && credit_ok && !reset) begin
                    grant_fire = 1'b1;
                    req_ready  = pick_onehot;
                    state_next = (sel_size != '0) ? ISSUE : IDLE;
                end
            end
            ISSUE:     state_next = GUARD;
            GUARD:     state_next = WAIT_DONE;
            WAIT_DONE: if (split_complete) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            split_addr <= '0;
            split_size <= '0;
        end else begin
            state <= state_next;
            if (grant_fire) begin
                grant_id   <= pick_idx;
                split_addr <= sel_addr;
                split_size <= sel_size;
                rr_ptr     <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            end
        end
    end

    // Simultaneous issue and retire cancel; each direction saturates at its bound.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else if (split_burst_valid && !resp_done) begin
            if (outstanding != CNT_W'(MAX_OUTSTANDING)) outstanding <= outstanding + CNT_W'(1);
        end else if (resp_done && !split_burst_valid) begin
            if (outstanding != '0) outstanding <= outstanding - CNT_W'(1);
        end
    end

`ifdef MEM_REQ_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_count <= '0;
            credit_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
            end
            if ((resp_done && outstanding == '0) ||
                (split_burst_valid && outstanding == CNT_W'(MAX_OUTSTANDING)))
                credit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_mem_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 64;
    localparam int SW      = 16;
    localparam int MAXO    = 8;

    logic                  clk;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*SW-1:0] req_size;
    logic [NUM_REQ-1:0]    req_ready;
    logic [AW-1:0]         split_addr;
    logic [SW-1:0]         split_size;
    logic                  split_valid;
    logic                  split_complete;
    logic                  split_burst_valid;
    logic                  resp_done;
    logic [1:0]            grant_id;
    logic                  busy;
    logic [3:0]            outstanding;
`ifdef MEM_REQ_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] grant_count;
    logic                  credit_err;
`endif

    mem_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .REQ_SIZE_WIDTH(SW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_size          (req_size),
        .req_ready         (req_ready),
        .split_addr        (split_addr),
        .split_size        (split_size),
        .split_valid       (split_valid),
        .split_complete    (split_complete),
        .split_burst_valid (split_burst_valid),
        .resp_done         (resp_done),
        .grant_id          (grant_id),
        .busy              (busy),
        .outstanding       (outstanding)
`ifdef MEM_REQ_ARB_STATS_EN
        ,
        .grant_count       (grant_count),
        .credit_err        (credit_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int sp_cnt = 0;
    int sp_delay = 3;

    typedef struct {
        logic [3:0] v;
        logic       b;
        logic       d;
        logic [3:0] ready;
        logic [1:0] gid;
        logic [3:0] outs;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; the splitter model drops split_complete on split_valid
    // and raises it again sp_delay cycles later.
    task automatic clk_edge();
        @(posedge clk);
        #1;
        if (split_valid) begin
            sp_cnt = sp_delay;
            split_complete = 1'b0;
        end else if (sp_cnt > 0) begin
            sp_cnt--;
            if (sp_cnt == 0) split_complete = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        split_burst_valid = 1'b0;
        resp_done = 1'b0;
        split_complete = 1'b1;
        sp_cnt = 0;
        clk_edge();
        clk_edge();
        reset = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        req_addr = '0;
        req_size = '0;
        do_reset();

        // Reset state
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_split_valid", split_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_split_addr", split_addr, 0);
        chk("rst_split_size", split_size, 0);
`ifdef MEM_REQ_ARB_STATS_EN
        chk("rst_credit_err", credit_err, 0);
`endif

        // Table: zero-size requests (consumed in IDLE) combined with credit traffic
        tbl[0]  = '{4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0, 4'd0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1, 4'd1};
        tbl[2]  = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 4'd1};
        tbl[3]  = '{4'b1001, 1'b1, 1'b0, 4'b1000, 2'd3, 4'd2};
        tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd3, 4'd3};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd3, 4'd4};
        tbl[6]  = '{4'b0110, 1'b1, 1'b0, 4'b0010, 2'd1, 4'd5};
        tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1, 4'd6};
        tbl[8]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2, 4'd7};
        tbl[9]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, 4'd8};
        tbl[10] = '{4'b0100, 1'b1, 1'b0, 4'b0000, 2'd2, 4'd8};
        tbl[11] = '{4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2, 4'd8};
        tbl[12] = '{4'b0011, 1'b0, 1'b1, 4'b0000, 2'd2, 4'd7};
        tbl[13] = '{4'b0011, 1'b0, 1'b1, 4'b0000, 2'd2, 4'd6};
        tbl[14] = '{4'b0011, 1'b0, 1'b0, 4'b0001, 2'd0, 4'd6};
        tbl[15] = '{4'b0011, 1'b0, 1'b0, 4'b0010, 2'd1, 4'd6};
        for (int k = 0; k < 16; k++) begin
            req_valid = tbl[k].v;
            split_burst_valid = tbl[k].b;
            resp_done = tbl[k].d;
            #1;
            chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].ready);
            clk_edge();
            chk($sformatf("tbl%0d_outstanding", k), outstanding, tbl[k].outs);
            chk($sformatf("tbl%0d_grant_id", k), grant_id, tbl[k].gid);
            chk($sformatf("tbl%0d_busy", k), busy, 0);
        end
        req_valid = '0;
        split_burst_valid = 1'b0;
        resp_done = 1'b0;
`ifdef MEM_REQ_ARB_STATS_EN
        chk("credit_err_sticky", credit_err, 1);
`endif

        // Continuous round robin with real issues, splitter done 3 cycles after split_valid
        do_reset();
        sp_delay = 3;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*AW +: AW] = 64'h100 + 64'(i) * 64'h1000;
            req_size[i*SW +: SW] = 16'h10 * 16'(i + 1);
        end
        req_valid = 4'b1111;
        begin
            int gcount;
            int order[5];
            gcount = 0;
            for (int cyc = 0; cyc < 60 && gcount < 5; cyc++) begin
                #1;
                if (req_ready != '0) begin
                    chk("rr_onehot", 64'($onehot(req_ready)), 1);
                    order[gcount] = onehot_idx(req_ready);
                    gcount++;
                    clk_edge();
                    chk("rr_pulse_1cycle", req_ready, 0);
                    chk("rr_issue_latency", split_valid, 1);
                    chk("rr_grant_id", grant_id, 64'(order[gcount-1]));
                end else begin
                    clk_edge();
                end
            end
            chk("rr_grant_total", gcount, 5);
            for (int k = 0; k < 5 && k < gcount; k++)
                chk($sformatf("rr_order%0d", k), order[k], k % 4);
        end
        req_valid = '0;

        // Requester 2 near a 4 KB boundary: operands held through the sequence
        do_reset();
        sp_delay = 6;
        req_addr[2*AW +: AW] = 64'h0FF0;
        req_size[2*SW +: SW] = 16'h0040;
        req_valid = 4'b0100;
        #1;
        chk("hold_ready", req_ready, 4'b0100);
        clk_edge();
        req_valid = '0;
        chk("hold_split_valid", split_valid, 1);
        split_burst_valid = 1'b1;
        clk_edge();
        chk("hold_split_valid_off", split_valid, 0);
        clk_edge();
        split_burst_valid = 1'b0;
        for (int c = 0; c < 20 && busy; c++) begin
            chk("hold_addr", split_addr, 64'h0FF0);
            chk("hold_size", split_size, 16'h0040);
            clk_edge();
        end
        chk("hold_done_idle", busy, 0);
        chk("hold_outstanding", outstanding, 2);

        // Credit block at outstanding=7 released by one resp_done
        do_reset();
        req_size[0 +: SW] = 16'h0020;
        split_burst_valid = 1'b1;
        for (int c = 0; c < 7; c++) clk_edge();
        split_burst_valid = 1'b0;
        chk("cred_at7", outstanding, 7);
        req_valid = 4'b0001;
        #1;
        chk("cred_blocked", req_ready, 0);
        resp_done = 1'b1;
        clk_edge();
        resp_done = 1'b0;
        #1;
        chk("cred_at6", outstanding, 6);
        chk("cred_grant", req_ready, 4'b0001);
        req_valid = '0;

        // Zero-size request on requester 1 advances the pointer without an issue
        do_reset();
        req_size = '0;
        req_valid = 4'b0010;
        #1;
        chk("zero_ready", req_ready, 4'b0010);
        clk_edge();
        chk("zero_busy", busy, 0);
        chk("zero_split_valid", split_valid, 0);
        req_valid = 4'b1111;
        #1;
        chk("zero_next_ptr", req_ready, 4'b0100);
        clk_edge();
        chk("zero_split_valid2", split_valid, 0);
        req_valid = '0;

        // Reset while in WAIT_DONE
        do_reset();
        sp_delay = 10;
        for (int i = 0; i < NUM_REQ; i++) req_size[i*SW +: SW] = 16'h0080;
        req_valid = 4'b0100;
        #1;
        chk("mid_ready", req_ready, 4'b0100);
        clk_edge();
        req_valid = '0;
        split_burst_valid = 1'b1;
        clk_edge();
        split_burst_valid = 1'b0;
        clk_edge();
        chk("mid_busy_before", busy, 1);
        chk("mid_outstanding_before", outstanding, 1);
        reset = 1'b1;
        req_valid = 4'b1100;
        #1;
        chk("mid_ready_in_reset", req_ready, 0);
        clk_edge();
        split_complete = 1'b1;
        sp_cnt = 0;
        chk("mid_busy", busy, 0);
        chk("mid_split_valid", split_valid, 0);
        chk("mid_outstanding", outstanding, 0);
        chk("mid_grant_id", grant_id, 0);
        reset = 1'b0;
        #1;
        chk("mid_post_reset_grant", req_ready, 4'b0100);
        clk_edge();
        chk("mid_post_issue", split_valid, 1);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
